tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receiving end of the 4:1 channel mux path. It accepts a serial stream of WIDTH-bit words, one channel per slot, aligned by a frame-sync marker. It routes each word to its channel register and flags each complete frame. It sits after the link that carries the multiplexed A/B/C/D channel words, and restores four parallel channel outputs.

## Interface
- WIDTH, 4, bits per channel word
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  WIDTH  multiplexed channel word
- din_valid  input  1  din carries a word this cycle
- din_sync  input  1  qualified by din_valid; marks the current word as slot 0 (channel A)
- a_out, b_out, c_out, d_out  output  WIDTH each  demultiplexed channel words
- slot  output  2  slot index expected for the next accepted word (00=A … 11=D)
- locked  output  1  frame alignment acquired
- frame_valid  output  1  one-cycle pulse: a complete A..D frame has landed on the outputs
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame

## Operation
- Reset value of every output and internal register is 0: a_out..d_out, slot, locked, frame_valid, sync_err, and the stage registers.
- Accepted word: din_valid=1 and either locked=1 or din_sync=1. All other words are dropped, so nothing is captured before the first sync.
- din_sync with din_valid=0 is ignored.
- Accepted word with din_sync=1:
  - It is treated as slot 0 and written to stage[0].
  - slot becomes 1 and locked is set.
  - If locked was already 1 and slot≠0, sync_err pulses and the partial frame is discarded, with no frame_valid for it. The new frame starts at A.
- Accepted word with din_sync=0: written to stage[slot], and slot increments modulo 4 (11→00 wraps).
- Frame completion: an accepted word in slot 3 triggers completion.
  - At the next edge, frame_valid pulses for exactly one cycle.
  - With TDM_DEMUX_SHADOW_EN, a_out..d_out load {stage0, stage1, stage2, din} on that same edge.
- din_valid gaps: slot and stage registers hold; there is no timeout.
- locked clears only on reset. Sync is never mandatory on every frame; a free-running slot count is legal.

## Timing
- Capture latency: 1 cycle. A word accepted at edge N is visible in its stage register after edge N.
- frame_valid latency: asserted in the cycle after the slot-3 word is presented. It is asserted together with the updated outputs (shadow mode).
- sync_err latency: asserted in the cycle after the offending word.
- sync_err and frame_valid are never high together. A sync on slot 3 is an error, not a completion.
- Back-to-back frames at full rate: frame_valid pulses every 4th cycle.
- Reset mid-frame: asynchronous clear of all state. The first accepted word after reset needs din_sync.

## Configuration
- TDM_DEMUX_SHADOW_EN defined:
  - a_out..d_out are a separate shadow bank, loaded atomically on frame completion only.
  - Outputs never show a mix of two frames.
  - A discarded partial frame never reaches the outputs.
- Undefined:
  - a_out..d_out are the stage registers themselves. Each channel updates 1 cycle after its own slot word, including words of a partial frame later discarded by sync_err.
  - frame_valid timing is unchanged.

## Structure
- Package tdm_pkg holds:
  - NUM_CH = 4
  - typedef slot_t (logic [1:0])
  - slot constants SLOT_A..SLOT_D
- Sub-module tdm_slot_ctr (2-bit slot counter with sync load, enable, locked flag) is natural. The data path and shadow bank stay in tdm_demux4.

## Test plan
- Reset, then 4 valid words 5,9,F,2 with sync on the first:
  - Outputs become A=5, B=9, C=F, D=2.
  - frame_valid pulses once, 1 cycle after the word 2.
  - slot returns to 0.
- Words with valid and no sync before the first sync: outputs stay 0, locked=0, no frame_valid.
- Sync on the third word of a frame:
  - sync_err pulses 1 cycle and no frame_valid.
  - The next 3 words complete a frame whose A is the synced word.
  - Shadow mode: old outputs hold until completion.
- Valid gaps of 1–3 idle cycles between the words of a frame: same result as the gapless case, and slot holds during gaps.
- Full-rate frames 1,2,3,4 then 6,7,8,9: frame_valid every 4 cycles, and outputs update atomically. Without the macro, each channel updates per slot.
- rst_n asserted after the second word of a frame: all outputs are 0 immediately. After release, a frame without sync is dropped.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and slot type for the four-channel TDM demultiplexer.
// Used by tdm_slot_ctr and tdm_demux4.
package tdm_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_A = 2'd0;
    localparam slot_t SLOT_B = 2'd1;
    localparam slot_t SLOT_C = 2'd2;
    localparam slot_t SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demultiplexer: wraps modulo 4 and loads on sync.
// The locked flag is sticky until reset.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sync,
    output logic [1:0] slot,
    output logic       locked
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot   <= SLOT_A;
            locked <= 1'b0;
        end else if (en) begin
            if (sync) begin
                // the sync word itself occupies slot A
                slot   <= SLOT_B;
                locked <= 1'b1;
            end else begin
                slot <= slot + 2'd1;
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer top: stage registers, frame and sync flags.
// Define TDM_DEMUX_SHADOW_EN for an atomically loaded output shadow bank.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_sync,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] d_out,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_valid,
    output logic             sync_err
);

    logic       accept;
    logic       complete;
    logic       mid_sync;
    logic [1:0] wr_slot;

    logic [WIDTH-1:0] stg0;
    logic [WIDTH-1:0] stg1;
    logic [WIDTH-1:0] stg2;

    assign accept   = din_valid & (locked | din_sync);
    assign wr_slot  = din_sync ? SLOT_A : slot;
    assign complete = accept & ~din_sync & (slot == SLOT_D);
    assign mid_sync = accept & din_sync & locked & (slot != SLOT_A);

    tdm_slot_ctr u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (accept),
        .sync   (din_sync),
        .slot   (slot),
        .locked (locked)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= complete;
            sync_err    <= mid_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg0 <= '0;
            stg1 <= '0;
            stg2 <= '0;
        end else if (accept) begin
            case (wr_slot)
                SLOT_A:  stg0 <= din;
                SLOT_B:  stg1 <= din;
                SLOT_C:  stg2 <= din;
                default: ;
            endcase
        end
    end

`ifdef TDM_DEMUX_SHADOW_EN

    // channel D goes straight from din into the bank on completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out <= '0;
            b_out <= '0;
            c_out <= '0;
            d_out <= '0;
        end else if (complete) begin
            a_out <= stg0;
            b_out <= stg1;
            c_out <= stg2;
            d_out <= din;
        end
    end

`else

    logic [WIDTH-1:0] stg3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg3 <= '0;
        end else if (accept && wr_slot == SLOT_D) begin
            stg3 <= din;
        end
    end

    assign a_out = stg0;
    assign b_out = stg1;
    assign c_out = stg2;
    assign d_out = stg3;

`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Randomized and directed bench for tdm_demux4 against a frame-level model.
// Honours TDM_DEMUX_SHADOW_EN the same way as the design.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_sync = 1'b0;
    logic [3:0] a_out, b_out, c_out, d_out;
    logic [1:0] slot;
    logic       locked, frame_valid, sync_err;

    int n_chk = 0;
    int n_fail = 0;

    // frame-level reference state
    bit m_locked;
    int m_pos;
    int m_buf [4];
    int m_out [4];
    bit m_fv;
    bit m_err;

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .din_sync    (din_sync),
        .a_out       (a_out),
        .b_out       (b_out),
        .c_out       (c_out),
        .d_out       (d_out),
        .slot        (slot),
        .locked      (locked),
        .frame_valid (frame_valid),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 0;
        m_pos    = 0;
        m_fv     = 0;
        m_err    = 0;
        for (int i = 0; i < 4; i++) begin
            m_buf[i] = 0;
            m_out[i] = 0;
        end
    endtask

    task automatic model_step(input bit v, input bit s, input int d);
        m_fv  = 0;
        m_err = 0;
        if (v && (m_locked || s)) begin
            if (s) begin
                if (m_locked && m_pos != 0) m_err = 1;
                m_pos    = 0;
                m_locked = 1;
            end
            m_buf[m_pos] = d;
`ifndef TDM_DEMUX_SHADOW_EN
            m_out[m_pos] = d;
`endif
            if (m_pos == 3) begin
                m_fv = 1;
`ifdef TDM_DEMUX_SHADOW_EN
                for (int i = 0; i < 4; i++) m_out[i] = m_buf[i];
`endif
            end
            m_pos = (m_pos + 1) % 4;
        end
    endtask

    task automatic check_all();
        check("a_out", a_out, m_out[0]);
        check("b_out", b_out, m_out[1]);
        check("c_out", c_out, m_out[2]);
        check("d_out", d_out, m_out[3]);
        check("slot", slot, m_pos);
        check("locked", locked, m_locked);
        check("frame_valid", frame_valid, m_fv);
        check("sync_err", sync_err, m_err);
    endtask

    // called at a negedge; leaves the bench at the next negedge
    task automatic cyc(input bit v, input bit s, input int d);
        din_valid = v;
        din_sync  = s;
        din       = d[3:0];
        @(posedge clk);
        model_step(v, s, d & 15);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, $urandom_range(15));
    endtask

    initial begin
        model_reset();
        #12;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        @(negedge clk);

        // words before the first sync are dropped
        cyc(1, 0, 3); cyc(1, 0, 7); cyc(1, 0, 1); cyc(1, 0, 8);
        check("pre_sync_locked", locked, 1'b0);

        // basic frame
        cyc(1, 1, 5); cyc(1, 0, 9); cyc(1, 0, 15); cyc(1, 0, 2);
        check("frame_pulse", frame_valid, 1'b1);
        check("frame_a", a_out, 5);
        check("frame_d", d_out, 2);
        check("frame_slot", slot, 0);

        // sync on third word, then complete from the synced word
        cyc(1, 1, 1); cyc(1, 0, 2); cyc(1, 1, 3);
        check("mid_sync_err", sync_err, 1'b1);
        cyc(1, 0, 4); cyc(1, 0, 6); cyc(1, 0, 7);
        check("resync_a", a_out, 3);

        // gaps inside a frame
        cyc(1, 1, 10); idle(2); cyc(1, 0, 11); idle(1);
        cyc(1, 0, 12); idle(3); cyc(1, 0, 13);
        check("gap_frame_c", c_out, 12);

        // full-rate free-running frames
        cyc(1, 0, 1); cyc(1, 0, 2); cyc(1, 0, 3); cyc(1, 0, 4);
        cyc(1, 0, 6); cyc(1, 0, 7); cyc(1, 0, 8); cyc(1, 0, 9);
        check("fullrate_b", b_out, 7);

        // reset after the second word of a frame
        cyc(1, 1, 5); cyc(1, 0, 6);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_a", a_out, 0);
        check("rst_b", b_out, 0);
        check("rst_locked", locked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, 9); cyc(1, 0, 9); cyc(1, 0, 9); cyc(1, 0, 9);
        check("post_rst_drop", frame_valid, 1'b0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(9) < 7, $urandom_range(11) == 0,
                $urandom_range(15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
